// File: rtl/zilla_muldiv_sched_if.sv
// Issue, multiplier, divider and writeback signals of the M-extension scheduler.
// The scheduler connects through the slave modport; the pipeline/units side uses master.
interface zilla_muldiv_sched_if #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned GPR_ADDR_WIDTH = 5
);
   logic                      issue_valid_i;
   logic [2:0]                issue_op_i;
   logic [GPR_ADDR_WIDTH-1:0] issue_rd_i;
   logic [XLEN-1:0]           rs1_val_i;
   logic [XLEN-1:0]           rs2_val_i;
   logic                      issue_ready_o;
   logic                      mul_start_o;
   logic [1:0]                mul_sign_o;
   logic [XLEN-1:0]           mul_hi_i;
   logic [XLEN-1:0]           mul_lo_i;
   logic                      div_start_o;
   logic                      div_signed_o;
   logic                      div_done_i;
   logic [XLEN-1:0]           div_quot_i;
   logic [XLEN-1:0]           div_rem_i;
   logic                      result_valid_o;
   logic [XLEN-1:0]           result_o;
   logic [GPR_ADDR_WIDTH-1:0] result_rd_o;
   logic                      mult_valid_o;
   logic                      div_busy_o;
   logic                      rem_busy_o;
   logic                      div_timeout_o;

   modport slave (
      input  issue_valid_i, issue_op_i, issue_rd_i, rs1_val_i, rs2_val_i,
      input  mul_hi_i, mul_lo_i, div_done_i, div_quot_i, div_rem_i,
      output issue_ready_o, mul_start_o, mul_sign_o, div_start_o, div_signed_o,
      output result_valid_o, result_o, result_rd_o,
      output mult_valid_o, div_busy_o, rem_busy_o, div_timeout_o
   );

   modport master (
      output issue_valid_i, issue_op_i, issue_rd_i, rs1_val_i, rs2_val_i,
      output mul_hi_i, mul_lo_i, div_done_i, div_quot_i, div_rem_i,
      input  issue_ready_o, mul_start_o, mul_sign_o, div_start_o, div_signed_o,
      input  result_valid_o, result_o, result_rd_o,
      input  mult_valid_o, div_busy_o, rem_busy_o, div_timeout_o
   );
endinterface

// File: rtl/zilla_muldiv_sched.sv
// Scheduler for the shared multiplier and iterative divider: one M-op at a time,
// divide corner cases resolved locally, tagged single-cycle result to writeback.
module zilla_muldiv_sched #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned GPR_ADDR_WIDTH = 5,
   parameter int unsigned MULT_LAT       = 3,
   parameter int unsigned DIV_TIMEOUT    = 64
) (
   input  logic                md_sched_clk,
   input  logic                md_sched_rst,
   input  logic                wdt_reset_i,
   zilla_muldiv_sched_if.slave md_if
);

   localparam int unsigned CNT_W = $clog2(DIV_TIMEOUT + MULT_LAT);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MUL_WAIT = 2'd1,
      S_DIV_WAIT = 2'd2,
      S_DONE     = 2'd3
   } state_e;

   state_e                    state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [2:0]                op_q;
   logic [GPR_ADDR_WIDTH-1:0] rd_q;
   logic [XLEN-1:0]           result_q;
   logic                      result_valid_q;
   logic                      ready_q;
   logic                      mult_valid_q;
   logic                      div_busy_q;
   logic                      rem_busy_q;
   logic                      timeout_q;
   logic [1:0]                mul_sign_q;
   logic                      div_signed_q;

   logic                      rst_any_c;
   logic                      fire_c;
   logic                      is_div_c;
   logic                      div_zero_c;
   logic                      div_ovf_c;
   logic                      corner_c;
   logic [XLEN-1:0]           corner_res_c;
   logic [1:0]                mul_sign_c;

   // Issue decode and local resolution of divide-by-zero / signed overflow
   always_comb begin
      rst_any_c    = md_sched_rst | wdt_reset_i;
      fire_c       = md_if.issue_valid_i & ready_q & ~rst_any_c;
      is_div_c     = md_if.issue_op_i[2];
      div_zero_c   = (md_if.rs2_val_i == '0);
      div_ovf_c    = ~md_if.issue_op_i[0]
                     & (md_if.rs1_val_i == {1'b1, {(XLEN-1){1'b0}}})
                     & (md_if.rs2_val_i == {XLEN{1'b1}});
      corner_c     = is_div_c & (div_zero_c | div_ovf_c);
      corner_res_c = '0;
      if (div_zero_c) begin
         corner_res_c = md_if.issue_op_i[1] ? md_if.rs1_val_i : {XLEN{1'b1}};
      end else if (div_ovf_c) begin
         corner_res_c = md_if.issue_op_i[1] ? '0 : md_if.rs1_val_i;
      end
      mul_sign_c = 2'b00;
      case (md_if.issue_op_i[1:0])
         2'b01:   mul_sign_c = 2'b11;
         2'b10:   mul_sign_c = 2'b10;
         default: mul_sign_c = 2'b00;
      endcase
   end

   // Start strobes and signedness must accompany the start in the fire cycle
   assign md_if.mul_start_o    = fire_c & ~is_div_c;
   assign md_if.div_start_o    = fire_c & is_div_c & ~corner_c;
   assign md_if.mul_sign_o     = (fire_c & ~is_div_c) ? mul_sign_c : mul_sign_q;
   assign md_if.div_signed_o   = (fire_c & is_div_c & ~corner_c) ? ~md_if.issue_op_i[0]
                                                                 : div_signed_q;
   assign md_if.issue_ready_o  = ready_q;
   assign md_if.result_valid_o = result_valid_q;
   assign md_if.result_o       = result_q;
   assign md_if.result_rd_o    = rd_q;
   assign md_if.mult_valid_o   = mult_valid_q;
   assign md_if.div_busy_o     = div_busy_q;
   assign md_if.rem_busy_o     = rem_busy_q;
   assign md_if.div_timeout_o  = timeout_q;

   always_ff @(posedge md_sched_clk) begin
      if (rst_any_c) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         op_q           <= '0;
         rd_q           <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         ready_q        <= 1'b1;
         mult_valid_q   <= 1'b0;
         div_busy_q     <= 1'b0;
         rem_busy_q     <= 1'b0;
         timeout_q      <= 1'b0;
         mul_sign_q     <= 2'b00;
         div_signed_q   <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         timeout_q      <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (fire_c) begin
                  op_q    <= md_if.issue_op_i;
                  rd_q    <= md_if.issue_rd_i;
                  ready_q <= 1'b0;
                  if (!is_div_c) begin
                     state_q      <= S_MUL_WAIT;
                     cnt_q        <= CNT_W'(MULT_LAT - 1);
                     mult_valid_q <= 1'b1;
                     mul_sign_q   <= mul_sign_c;
                  end else begin
                     div_busy_q <= ~md_if.issue_op_i[1];
                     rem_busy_q <= md_if.issue_op_i[1];
                     if (corner_c) begin
                        state_q        <= S_DONE;
                        result_q       <= corner_res_c;
                        result_valid_q <= 1'b1;
                     end else begin
                        state_q      <= S_DIV_WAIT;
                        cnt_q        <= '0;
                        div_signed_q <= ~md_if.issue_op_i[0];
                     end
                  end
               end
            end
            S_MUL_WAIT: begin
               if (cnt_q == '0) begin
                  result_q       <= (op_q == 3'd0) ? md_if.mul_lo_i : md_if.mul_hi_i;
                  result_valid_q <= 1'b1;
                  state_q        <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_DIV_WAIT: begin
               // A done arriving on the timeout cycle still delivers its result
               if (md_if.div_done_i) begin
                  result_q       <= op_q[1] ? md_if.div_rem_i : md_if.div_quot_i;
                  result_valid_q <= 1'b1;
                  state_q        <= S_DONE;
               end else if (cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
                  result_q       <= {XLEN{1'b1}};
                  result_valid_q <= 1'b1;
                  timeout_q      <= 1'b1;
                  state_q        <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               state_q      <= S_IDLE;
               ready_q      <= 1'b1;
               mult_valid_q <= 1'b0;
               div_busy_q   <= 1'b0;
               rem_busy_q   <= 1'b0;
               mul_sign_q   <= 2'b00;
               div_signed_q <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zilla_muldiv_sched.sv
// Directed self-checking bench for zilla_muldiv_sched with hand-computed expectations.
module tb_zilla_muldiv_sched;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned GPR_W       = 5;
   localparam int unsigned MULT_LAT    = 3;
   localparam int unsigned DIV_TIMEOUT = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic wdt = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   zilla_muldiv_sched_if #(.XLEN(XLEN), .GPR_ADDR_WIDTH(GPR_W)) bus ();

   zilla_muldiv_sched #(
      .XLEN(XLEN), .GPR_ADDR_WIDTH(GPR_W), .MULT_LAT(MULT_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)
   ) dut (
      .md_sched_clk(clk),
      .md_sched_rst(rst),
      .wdt_reset_i (wdt),
      .md_if       (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [2:0] op, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b);
      bus.issue_valid_i = 1'b1;
      bus.issue_op_i    = op;
      bus.issue_rd_i    = rd;
      bus.rs1_val_i     = a;
      bus.rs2_val_i     = b;
      #1;
   endtask

   task automatic release_issue();
      tick();
      bus.issue_valid_i = 1'b0;
      #1;
   endtask

   task automatic wait_result(input int max, output int n);
      n = 0;
      while (!bus.result_valid_o && n < max) begin
         tick();
         n++;
      end
   endtask

   int n;

   initial begin
      bus.issue_valid_i = 1'b0;
      bus.issue_op_i    = '0;
      bus.issue_rd_i    = '0;
      bus.rs1_val_i     = '0;
      bus.rs2_val_i     = '0;
      bus.mul_hi_i      = '0;
      bus.mul_lo_i      = '0;
      bus.div_done_i    = 1'b0;
      bus.div_quot_i    = '0;
      bus.div_rem_i     = '0;

      // Reset state
      repeat (3) tick();
      rst = 1'b0;
      #1;
      check("rst_ready",   32'(bus.issue_ready_o),  32'd1);
      check("rst_valid",   32'(bus.result_valid_o), 32'd0);
      check("rst_busy",    32'({bus.mult_valid_o, bus.div_busy_o, bus.rem_busy_o}), 32'd0);
      check("rst_tmo",     32'(bus.div_timeout_o),  32'd0);
      check("rst_result",  bus.result_o,            32'd0);

      // MUL 7*6, product 42 on the low half; issue_valid held with another op while busy
      bus.mul_lo_i = 32'd42;
      bus.mul_hi_i = 32'd0;
      present(3'd0, 5'd5, 32'd7, 32'd6);
      check("mul_start",   32'(bus.mul_start_o),  32'd1);
      check("mul_nodiv",   32'(bus.div_start_o),  32'd0);
      check("mul_sign",    32'(bus.mul_sign_o),   32'd0);
      tick();
      present(3'd4, 5'd31, 32'd1, 32'd0);
      for (int k = 1; k <= 3; k++) begin
         check("mul_mv",     32'(bus.mult_valid_o),   32'd1);
         check("mul_nready", 32'(bus.issue_ready_o),  32'd0);
         check("mul_nostr",  32'(bus.result_valid_o), 32'd0);
         check("mul_ign",    32'({bus.mul_start_o, bus.div_start_o}), 32'd0);
         tick();
      end
      bus.issue_valid_i = 1'b0;
      check("mul_valid",   32'(bus.result_valid_o), 32'd1);
      check("mul_result",  bus.result_o,            32'd42);
      check("mul_rd",      32'(bus.result_rd_o),    32'd5);
      check("mul_mv_done", 32'(bus.mult_valid_o),   32'd1);
      tick();
      check("mul_idle_v",  32'(bus.result_valid_o), 32'd0);
      check("mul_idle_r",  32'(bus.issue_ready_o),  32'd1);
      check("mul_idle_mv", 32'(bus.mult_valid_o),   32'd0);

      // MULHU all-ones, fired back-to-back in the cycle after DONE
      bus.mul_hi_i = 32'hFFFF_FFFE;
      bus.mul_lo_i = 32'h0000_0001;
      present(3'd3, 5'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("mulhu_start", 32'(bus.mul_start_o), 32'd1);
      check("mulhu_sign",  32'(bus.mul_sign_o),  32'd0);
      release_issue();
      wait_result(10, n);
      check("mulhu_lat",    32'(n + 1),        32'(MULT_LAT + 1));
      check("mulhu_result", bus.result_o,      32'hFFFF_FFFE);
      tick();

      // MULH and MULHSU sign encodings, held while busy
      bus.mul_hi_i = 32'h0000_1234;
      present(3'd1, 5'd7, 32'd3, 32'd4);
      check("mulh_sign",  32'(bus.mul_sign_o), 32'd3);
      release_issue();
      check("mulh_hold",  32'(bus.mul_sign_o), 32'd3);
      wait_result(10, n);
      check("mulh_result", bus.result_o, 32'h0000_1234);
      tick();
      present(3'd2, 5'd8, 32'd3, 32'd4);
      check("mulhsu_sign", 32'(bus.mul_sign_o), 32'd2);
      release_issue();
      wait_result(10, n);
      check("mulhsu_result", bus.result_o, 32'h0000_1234);
      tick();

      // DIV by zero: no divider start, all ones at T+1
      present(3'd4, 5'd1, 32'd123, 32'd0);
      check("dz_nostart", 32'({bus.div_start_o, bus.mul_start_o}), 32'd0);
      release_issue();
      check("dz_valid",  32'(bus.result_valid_o), 32'd1);
      check("dz_result", bus.result_o,            32'hFFFF_FFFF);
      check("dz_busy",   32'({bus.div_busy_o, bus.rem_busy_o}), 32'd2);
      tick();
      check("dz_idle",   32'({bus.issue_ready_o, bus.div_busy_o}), 32'd2);

      // REMU by zero returns the dividend
      present(3'd7, 5'd2, 32'd9, 32'd0);
      check("rz_nostart", 32'(bus.div_start_o), 32'd0);
      release_issue();
      check("rz_valid",  32'(bus.result_valid_o), 32'd1);
      check("rz_result", bus.result_o,            32'd9);
      check("rz_busy",   32'({bus.div_busy_o, bus.rem_busy_o}), 32'd1);
      tick();

      // Signed overflow corner for REM and DIV
      present(3'd6, 5'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      check("ovr_nostart", 32'(bus.div_start_o), 32'd0);
      release_issue();
      check("ovr_valid",  32'(bus.result_valid_o), 32'd1);
      check("ovr_result", bus.result_o,            32'd0);
      tick();
      present(3'd4, 5'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      release_issue();
      check("ovd_valid",  32'(bus.result_valid_o), 32'd1);
      check("ovd_result", bus.result_o,            32'h8000_0000);
      tick();

      // Same operands unsigned are not a corner case
      present(3'd5, 5'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      check("ovu_start",  32'(bus.div_start_o),  32'd1);
      check("ovu_signed", 32'(bus.div_signed_o), 32'd0);
      release_issue();
      check("ovu_wait",   32'(bus.result_valid_o), 32'd0);
      bus.div_done_i = 1'b1;
      bus.div_quot_i = 32'd0;
      bus.div_rem_i  = 32'h8000_0000;
      tick();
      bus.div_done_i = 1'b0;
      check("ovu_result", bus.result_o, 32'd0);
      check("ovu_valid",  32'(bus.result_valid_o), 32'd1);
      tick();

      // DIVU 100/7 with done ten cycles after start
      present(3'd5, 5'd7, 32'd100, 32'd7);
      check("divu_start",  32'(bus.div_start_o),  32'd1);
      check("divu_signed", 32'(bus.div_signed_o), 32'd0);
      release_issue();
      for (int k = 1; k <= 9; k++) begin
         check("divu_busy",  32'({bus.div_busy_o, bus.issue_ready_o, bus.result_valid_o}), 32'd4);
         tick();
      end
      bus.div_done_i = 1'b1;
      bus.div_quot_i = 32'd14;
      bus.div_rem_i  = 32'd2;
      tick();
      bus.div_done_i = 1'b0;
      check("divu_valid",  32'(bus.result_valid_o), 32'd1);
      check("divu_result", bus.result_o,            32'd14);
      check("divu_rd",     32'(bus.result_rd_o),    32'd7);
      check("divu_busy_d", 32'(bus.div_busy_o),     32'd1);
      tick();
      check("divu_idle",   32'({bus.issue_ready_o, bus.div_busy_o}), 32'd2);

      // REM selects the remainder and flags rem_busy
      present(3'd6, 5'd10, 32'd100, 32'd7);
      check("rem_signed", 32'(bus.div_signed_o), 32'd1);
      release_issue();
      check("rem_busy",   32'({bus.mult_valid_o, bus.div_busy_o, bus.rem_busy_o}), 32'd1);
      check("rem_shold",  32'(bus.div_signed_o), 32'd1);
      bus.div_done_i = 1'b1;
      tick();
      bus.div_done_i = 1'b0;
      check("rem_result", bus.result_o, 32'd2);
      tick();

      // DIV timeout: no done ever arrives
      present(3'd4, 5'd9, 32'd50, 32'd3);
      release_issue();
      for (int k = 1; k <= 63; k++) begin
         check("tmo_wait", 32'({bus.div_timeout_o, bus.result_valid_o}), 32'd0);
         tick();
      end
      check("tmo_edge",   32'({bus.div_timeout_o, bus.result_valid_o}), 32'd0);
      tick();
      check("tmo_strobe", 32'(bus.div_timeout_o),  32'd1);
      check("tmo_valid",  32'(bus.result_valid_o), 32'd1);
      check("tmo_result", bus.result_o,            32'hFFFF_FFFF);
      check("tmo_rd",     32'(bus.result_rd_o),    32'd9);
      tick();
      check("tmo_clear",  32'({bus.div_timeout_o, bus.issue_ready_o}), 32'd1);

      // Done on the timeout cycle wins
      present(3'd5, 5'd11, 32'd50, 32'd10);
      release_issue();
      repeat (63) tick();
      bus.div_done_i = 1'b1;
      bus.div_quot_i = 32'd5;
      tick();
      bus.div_done_i = 1'b0;
      check("dwin_tmo",    32'(bus.div_timeout_o), 32'd0);
      check("dwin_result", bus.result_o,           32'd5);
      tick();

      // Watchdog abort mid-divide; a late done yields nothing
      present(3'd6, 5'd12, 32'd100, 32'd7);
      release_issue();
      tick();
      wdt = 1'b1;
      #1;
      check("wdt_nostart", 32'({bus.mul_start_o, bus.div_start_o}), 32'd0);
      tick();
      wdt = 1'b0;
      #1;
      check("wdt_ready", 32'(bus.issue_ready_o), 32'd1);
      check("wdt_busy",  32'({bus.mult_valid_o, bus.div_busy_o, bus.rem_busy_o}), 32'd0);
      bus.div_done_i = 1'b1;
      bus.div_rem_i  = 32'd2;
      tick();
      bus.div_done_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("wdt_noresult", 32'(bus.result_valid_o), 32'd0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
